imm_encoder: RTL and testbench
==============================

# imm_encoder

Sequential immediate encoder: the inverse of the processor's immediate extend stage. Takes a 32-bit value plus an immediate-source selector and produces the 24-bit instruction immediate field that the extend stage expands back to that value, or flags it as unencodable. Sits in the program loader / self-test instruction generator path, ahead of instruction memory writes. It includes an iterative rotated-immediate search, one rotation per cycle.

## Interface
- `N`, 24: width of the produced immediate field; only 24 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  encoder can accept a request.
- `src`  in  2  immediate source: 00 imm8, 01 imm12, 10 branch, 11 rotated imm8.
- `value`  in  32  value to encode (branch: absolute target address).
- `pc`  in  32  address of the branch instruction; used only for `src`=10.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `field`  out  N  encoded immediate field.
- `ok`  out  1  1 = encodable; 0 = not encodable, `field` = 0.

## Operation
- States: IDLE, CALC, SEARCH, DONE. Reset state is IDLE.
- IDLE: `in_ready`=1. `in_valid`&&`in_ready` latches `src`, `value`, `pc`. Next state is SEARCH for `src`=11, otherwise CALC.
- CALC (one cycle) computes the result, then goes to DONE:
  - 00: ok iff `value`[31:8]==0; field = {16'b0, value[7:0]}.
  - 01: ok iff `value`[31:12]==0; field = {12'b0, value[11:0]}.
  - 10: off = value − (pc + 8), computed modulo 2^32. ok iff off[1:0]==0 and off[31:25] all equal off[25]. field = off[25:2].
- SEARCH: 4-bit counter r starts at 0. Each cycle tests t = rol(value, 2r).
  - Hit (t[31:8]==0): ok=1, field = {12'b0, r, t[7:0]}, go to DONE.
  - Miss at r=15: ok=0, go to DONE. Otherwise r increments.
  - Lowest hitting r wins. `value`=0 hits at r=0.
- DONE: `out_valid`=1. `field` and `ok` are held stable until `out_ready`=1, then the block returns to IDLE.
- `in_ready`=0 in CALC, SEARCH and DONE. A new request is never accepted in the same cycle as the output handshake.
- Whenever ok=0, `field` is forced to 0.
- Inputs are ignored outside IDLE.

## Timing
- Reset values: `in_ready`=0 while `rst` is high and 1 after, `out_valid`=0, `field`=0, `ok`=0, r=0.
- Cycle numbering: accept edge = cycle 0.
- `src` 00/01/10: `out_valid` rises after edge 2 (CALC occupies cycle 1).
- `src`=11 with hit at rotation r: `out_valid` rises after edge r+2.
- `src`=11 with full miss: `out_valid` rises after edge 17.
- Minimum spacing between acceptances: result handshake cycle plus one IDLE cycle.
- Reset mid-operation (CALC, SEARCH or DONE): the next edge returns to IDLE with all outputs at reset values. The pending result is discarded.
- `rst` and `in_valid` high together: no acceptance.

## Configuration
- `IMM_ENCODER_ROT_EN` defined: SEARCH state, counter r and rotation logic are compiled in; `src`=11 behaves as described above.
- Not defined: SEARCH and r are absent. `src`=11 goes IDLE→CALC→DONE with ok=0 and field=0, at the same latency as the other sources.

## Structure
- Shared package `imm_pkg`:
  - enum `imm_src_t` (IMM8, IMM12, BRANCH, ROT), shared with the extend stage's selector.
  - `PC_AHEAD` = 8.
  - `IMM_FIELD_W` = 24.
  - state enum `imm_enc_state_t`.
- Sub-module `imm_branch_off`: purely combinational off/range/alignment check for `src`=10. The FSM, counter and rotation stay in `imm_encoder`.

## Test plan
- `src`=00, `value`=0x000000AB → field 0x0000AB, ok=1, `out_valid` after edge 2. `value`=0x100 → ok=0, field 0.
- `src`=10, `pc`=0x100, `value`=0xF8 → field 0xFFFFFC, ok=1. `value`=0x102 → ok=0 (misaligned). `pc`=0, `value`=0x02000008 → ok=0 (out of range).
- `src`=11, `value`=0xFF000000 → field 0x0004FF, ok=1, `out_valid` after edge 6. `value`=0x00000101 → ok=0, `out_valid` after edge 17.
- Backpressure: hold `out_ready`=0 for 4 cycles after `out_valid` while `in_valid`=1 with new data → field/ok stable, `in_ready`=0, no acceptance. Release → IDLE, then the next request is accepted.
- Assert `rst` at cycle 3 of a `src`=11 search → after that edge `out_valid`=0 and `in_ready` goes to 1 once `rst` drops. A following `src`=01, `value`=0xFFF request → field 0x000FFF, ok=1.
- Build without `IMM_ENCODER_ROT_EN`: `src`=11, `value`=0xFF000000 → ok=0, field 0, `out_valid` after edge 2.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: immediate-source selector shared with the extend stage, encoder states and constants
package imm_pkg;
  typedef enum logic [1:0] {IMM8, IMM12, BRANCH, ROT} imm_src_t;
  typedef enum logic [1:0] {IDLE, CALC, SEARCH, DONE} imm_enc_state_t;
  localparam logic [31:0] PC_AHEAD = 32'd8;
  localparam int IMM_FIELD_W = 24;
endpackage

// File: rtl/imm_branch_off.sv
// imm_branch_off: branch offset = target - (pc + 8), word alignment and 26-bit signed range check
//   in: value_i (target), pc_i   out: field_o (off[25:2], 0 when unencodable), ok_o
module imm_branch_off
  import imm_pkg::*;
(
  input  logic [31:0]            value_i,
  input  logic [31:0]            pc_i,
  output logic [IMM_FIELD_W-1:0] field_o,
  output logic                   ok_o
);
  logic [31:0] off;
  assign off = value_i - (pc_i + PC_AHEAD);
  assign ok_o = off[1:0] == 2'b00 && (&off[31:25] || ~|off[31:25]);
  assign field_o = ok_o ? off[25:2] : '0;
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: 32-bit value + immediate source -> 24-bit instruction immediate field, or unencodable
//   in: clk, rst, in_valid, src, value, pc, out_ready   out: in_ready, out_valid, field, ok
//   IMM_ENCODER_ROT_EN: builds the rotated-imm8 search (src=11); without it src=11 reports ok=0
module imm_encoder
  import imm_pkg::*;
#(
  parameter int N = IMM_FIELD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   src,
  input  logic [31:0]  value,
  input  logic [31:0]  pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] field,
  output logic         ok
);
  imm_enc_state_t state_q, state_d;
  imm_src_t src_q;
  logic [31:0] value_q, pc_q;
  logic [N-1:0] field_q, field_d, br_field, calc_field;
  logic ok_q, ok_d, out_valid_q, out_valid_d, br_ok, calc_ok;
  imm_branch_off u_branch_off (
    .value_i(value_q),
    .pc_i(pc_q),
    .field_o(br_field),
    .ok_o(br_ok)
  );
  assign calc_ok = src_q == IMM8 ? ~|value_q[31:8] : src_q == IMM12 ? ~|value_q[31:12] : src_q == BRANCH && br_ok;
  assign calc_field = !calc_ok ? '0 : src_q == IMM8 ? N'(value_q[7:0]) : src_q == IMM12 ? N'(value_q[11:0]) : br_field;
`ifdef IMM_ENCODER_ROT_EN
  logic [3:0] r_q, r_d;
  logic [4:0] sh;
  logic [31:0] rot;
  assign sh = {r_q, 1'b0};
  // a shift by 32 yields 0, so r=0 is the unrotated value
  assign rot = (value_q << sh) | (value_q >> (6'd32 - {1'b0, sh}));
  always_ff @(posedge clk) r_q <= rst ? 4'd0 : r_d;
`endif
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    ok_d = ok_q;
    out_valid_d = out_valid_q;
`ifdef IMM_ENCODER_ROT_EN
    r_d = r_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
`ifdef IMM_ENCODER_ROT_EN
        state_d = imm_src_t'(src) == ROT ? SEARCH : CALC;
        r_d = '0;
`else
        state_d = CALC;
`endif
      end
      CALC: begin
        ok_d = calc_ok;
        field_d = calc_field;
        state_d = DONE;
      end
`ifdef IMM_ENCODER_ROT_EN
      SEARCH: begin
        ok_d = ~|rot[31:8];
        field_d = ok_d ? N'({r_q, rot[7:0]}) : '0;
        state_d = ok_d || &r_q ? DONE : SEARCH;
        r_d = r_q + 4'd1;
      end
`endif
      // out_valid rises one cycle after entering DONE; the result is already stable by then
      DONE: begin
        out_valid_d = !(out_valid_q && out_ready);
        state_d = out_valid_q && out_ready ? IDLE : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      field_q <= '0;
      ok_q <= 1'b0;
      out_valid_q <= 1'b0;
      src_q <= IMM8;
      value_q <= '0;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      ok_q <= ok_d;
      out_valid_q <= out_valid_d;
      if (in_ready && in_valid) begin
        src_q <= imm_src_t'(src);
        value_q <= value;
        pc_q <= pc;
      end
    end
  end
  assign in_ready = state_q == IDLE && !rst;
  assign out_valid = out_valid_q;
  assign field = field_q;
  assign ok = ok_q;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: directed vectors checked every cycle against a spec-level model of imm_encoder
module tb_imm_encoder;
  typedef struct packed {
    logic        ok;
    logic [23:0] f;
    logic [4:0]  lat;
  } res_t;
`ifdef IMM_ENCODER_ROT_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, ok;
  logic [1:0] src = 2'd0;
  logic [31:0] value = '0, pc = '0;
  logic [23:0] field;
  int compared = 0, errors = 0, ecnt = 0, due = 0;
  bit pending = 1'b0, rst_seen = 1'b0;
  res_t exp_r;
  imm_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .src(src),
    .value(value), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .field(field), .ok(ok)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ecnt++;
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, ecnt);
    end
  endtask
  function automatic res_t mdl(input logic [1:0] s, input logic [31:0] v, input logic [31:0] p);
    res_t r;
    int o;
    logic [31:0] t;
    bit found;
    r = '0;
    r.lat = 5'd2;
    case (s)
      2'd0: if (v < 32'd256) begin r.ok = 1'b1; r.f = v[23:0]; end
      2'd1: if (v < 32'd4096) begin r.ok = 1'b1; r.f = v[23:0]; end
      2'd2: begin
        o = int'(v - p - 32'd8);
        if (o % 4 == 0 && o >= -33554432 && o < 33554432) begin r.ok = 1'b1; r.f = 24'(o / 4); end
      end
      default: if (ROT) begin
        t = v;
        found = 1'b0;
        r.lat = 5'd17;
        for (int k = 0; k < 16; k++) begin
          if (!found && t < 32'd256) begin
            found = 1'b1;
            r.ok = 1'b1;
            r.f = {12'd0, 4'(k), t[7:0]};
            r.lat = 5'(k + 2);
          end
          t = {t[29:0], t[31:30]};
        end
      end
    endcase
    return r;
  endfunction
  always @(negedge clk) if (ecnt > 0) begin
    if (rst) begin
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      pending = 1'b0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("reset_out_valid", {31'd0, out_valid}, 0);
        chk("reset_field", {8'd0, field}, 0);
        chk("reset_ok", {31'd0, ok}, 0);
        rst_seen = 1'b0;
      end
      chk("in_ready", {31'd0, in_ready}, {31'd0, !pending});
      chk("out_valid", {31'd0, out_valid}, {31'd0, pending && ecnt >= due});
      if (pending && out_valid) begin
        chk("field", {8'd0, field}, {8'd0, exp_r.f});
        chk("ok", {31'd0, ok}, {31'd0, exp_r.ok});
      end
      if (pending && out_valid && out_ready) pending = 1'b0;
      else if (!pending && in_valid) begin
        exp_r = mdl(src, value, pc);
        pending = 1'b1;
        due = ecnt + 1 + int'(exp_r.lat);
      end
    end
  end
  task automatic pin(input logic [1:0] s, input logic [31:0] v, input logic [31:0] p,
                     input logic [23:0] lf, input logic lok, input int llat);
    res_t m;
    m = mdl(s, v, p);
    chk("pin_field", {8'd0, m.f}, {8'd0, lf});
    chk("pin_ok", {31'd0, m.ok}, {31'd0, lok});
    chk("pin_lat", {27'd0, m.lat}, llat);
  endtask
  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    chk("accept_timeout", {31'd0, in_ready}, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask
  task automatic start(input logic [1:0] s, input logic [31:0] v, input logic [31:0] p,
                       input logic [23:0] lf, input logic lok, input int llat);
    pin(s, v, p, lf, lok, llat);
    @(posedge clk); #2;
    in_valid = 1'b1; src = s; value = v; pc = p;
    wait_accept();
  endtask
  task automatic wait_done();
    int n = 0;
    while (pending && n < 60) begin @(negedge clk); n++; end
    chk("done_timeout", {31'd0, pending}, 0);
  endtask
  task automatic req(input logic [1:0] s, input logic [31:0] v, input logic [31:0] p,
                     input logic [23:0] lf, input logic lok, input int llat);
    start(s, v, p, lf, lok, llat);
    wait_done();
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    req(2'd0, 32'h0000_00AB, 32'h0, 24'h0000AB, 1'b1, 2);
    req(2'd0, 32'h0000_0100, 32'h0, 24'h000000, 1'b0, 2);
    req(2'd1, 32'h0000_0FFF, 32'h0, 24'h000FFF, 1'b1, 2);
    req(2'd1, 32'h0000_1000, 32'h0, 24'h000000, 1'b0, 2);
    req(2'd2, 32'h0000_00F8, 32'h100, 24'hFFFFFC, 1'b1, 2);
    req(2'd2, 32'h0000_0102, 32'h100, 24'h000000, 1'b0, 2);
    req(2'd2, 32'h0200_0008, 32'h0, 24'h000000, 1'b0, 2);
    req(2'd2, 32'h0000_0208, 32'h100, 24'h000040, 1'b1, 2);
    req(2'd2, 32'h0200_0004, 32'h0, 24'h7FFFFF, 1'b1, 2);
    req(2'd3, 32'hFF00_0000, 32'h0, ROT ? 24'h0004FF : 24'h0, ROT, ROT ? 6 : 2);
    req(2'd3, 32'h0000_0101, 32'h0, 24'h000000, 1'b0, ROT ? 17 : 2);
    req(2'd3, 32'h0000_0000, 32'h0, 24'h000000, ROT, 2);
    req(2'd3, 32'h0000_00C3, 32'h0, ROT ? 24'h0000C3 : 24'h0, ROT, 2);
    out_ready = 1'b0;
    start(2'd0, 32'h0000_0077, 32'h0, 24'h000077, 1'b1, 2);
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    chk("bp_out_valid_timeout", {31'd0, out_valid}, 1);
    pin(2'd1, 32'h0000_0345, 32'h0, 24'h000345, 1'b1, 2);
    @(posedge clk); #2;
    in_valid = 1'b1; src = 2'd1; value = 32'h0000_0345; pc = 32'h0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 0);
      chk("bp_field_hold", {8'd0, field}, 32'h77);
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_accept();
    wait_done();
    start(2'd3, 32'h0000_0101, 32'h0, 24'h000000, 1'b0, ROT ? 17 : 2);
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 1);
    req(2'd1, 32'h0000_0FFF, 32'h0, 24'h000FFF, 1'b1, 2);
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end
endmodule
